// File: rtl/fetch_target_queue_pkg.sv
// Shared frontend types: BPU/IFU interface structs, handshake, and fetch-target queue entry.
package fetch_target_queue_pkg;

    localparam int unsigned PLEN            = 32;
    localparam int unsigned INSTR_PER_FETCH = 4;
    localparam int unsigned FETCH_WIDTH     = 16;
    localparam int unsigned SLOT_IDX_W      = $clog2(INSTR_PER_FETCH);

    localparam int unsigned FTQ_DEPTH = 8;
    localparam int unsigned FTQ_IDX_W = $clog2(FTQ_DEPTH);
    localparam int unsigned FTQ_CNT_W = $clog2(FTQ_DEPTH + 1);

    typedef struct packed {
        int unsigned plen;
        int unsigned instr_per_fetch;
        int unsigned fetch_width;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{
        plen:            PLEN,
        instr_per_fetch: INSTR_PER_FETCH,
        fetch_width:     FETCH_WIDTH
    };

    typedef logic [PLEN-1:0] plen_t;

    typedef struct packed {
        logic valid;
        logic ready;
    } handshake_t;

    typedef struct packed {
        plen_t pc;
    } ifu_to_bpu_t;

    typedef struct packed {
        logic                  pred_slot_valid;
        logic [SLOT_IDX_W-1:0] pred_slot_idx;
        plen_t                 pred_slot_target;
        plen_t                 npc;
    } bpu_to_ifu_t;

    typedef struct packed {
        plen_t                 pc;
        logic                  pred_slot_valid;
        logic [SLOT_IDX_W-1:0] pred_slot_idx;
        plen_t                 pred_slot_target;
        plen_t                 npc;
    } ftq_entry_t;

endpackage

// File: rtl/fetch_target_queue.sv
// Frontend PC generator and in-order fetch-target queue between the BPU and the fetch stage.
// Redirects flush the queue and reload the fetch PC; a full queue stalls the PC (no pop-through).
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter cfg_t        Cfg      = EmptyCfg,
    parameter int unsigned DEPTH    = FTQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output ifu_to_bpu_t                  ifu_to_bpu_o,
    output handshake_t                   ifu_to_bpu_hs_o,
    input  handshake_t                   bpu_to_ifu_hs_i,
    input  bpu_to_ifu_t                  bpu_to_ifu_i,
    input  logic                         redirect_valid_i,
    input  logic [Cfg.plen-1:0]          redirect_pc_i,
    output logic                         deq_valid_o,
    input  logic                         deq_ready_i,
    output ftq_entry_t                   deq_entry_o,
    output logic [$clog2(DEPTH)-1:0]     deq_ftq_idx_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PLEN-1:0]  r_pc;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    ftq_entry_t       r_mem [DEPTH];

    logic w_full;
    logic w_req_valid;
    logic w_enq;
    logic w_deq_valid;
    logic w_deq;
    logic w_unused_hs_valid;

    // BPU valid carries no information for us; the prediction is combinational on pc.
    assign w_unused_hs_valid = bpu_to_ifu_hs_i.valid;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_req_valid = !rst_i && !redirect_valid_i && !w_full;
    assign w_enq       = w_req_valid && bpu_to_ifu_hs_i.ready;
    assign w_deq_valid = !rst_i && (r_count != '0);
    assign w_deq       = w_deq_valid && deq_ready_i && !redirect_valid_i;

    // Pointer, occupancy and fetch-PC state; redirect outranks enqueue and dequeue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc    <= PLEN'(RESET_PC);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid_i) begin
            r_pc    <= redirect_pc_i;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + IDX_W'(1);
                r_pc   <= bpu_to_ifu_i.npc;
            end
            if (w_deq) begin
                r_head <= r_head + IDX_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is left unreset; only pointers qualify its contents.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{
                pc:               r_pc,
                pred_slot_valid:  bpu_to_ifu_i.pred_slot_valid,
                pred_slot_idx:    bpu_to_ifu_i.pred_slot_idx,
                pred_slot_target: bpu_to_ifu_i.pred_slot_target,
                npc:              bpu_to_ifu_i.npc
            };
        end
    end

    assign ifu_to_bpu_o.pc = r_pc;
    assign ifu_to_bpu_hs_o = '{valid: w_req_valid, ready: 1'b1};
    assign deq_valid_o     = w_deq_valid;
    assign deq_entry_o     = r_mem[r_head];
    assign deq_ftq_idx_o   = r_head;
    assign count_o         = r_count;

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue: vector table for basic flow, hand sequences for full/redirect/wrap.
module tb_fetch_target_queue;
    import fetch_target_queue_pkg::*;

    localparam logic [31:0] B = 32'h8000_0000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    ifu_to_bpu_t          ifu_pc;
    handshake_t           req_hs;
    handshake_t           bpu_hs;
    bpu_to_ifu_t          bpu_pred;
    logic                 redir = 1'b0;
    logic [PLEN-1:0]      redir_pc = '0;
    logic                 deq_valid;
    logic                 deq_ready = 1'b0;
    ftq_entry_t           deq_entry;
    logic [FTQ_IDX_W-1:0] deq_idx;
    logic [FTQ_CNT_W-1:0] count;
    logic                 bpu_rdy = 1'b0;
    logic                 take_en = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    fetch_target_queue #(
        .Cfg      (EmptyCfg),
        .DEPTH    (FTQ_DEPTH),
        .RESET_PC (B)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ifu_to_bpu_o     (ifu_pc),
        .ifu_to_bpu_hs_o  (req_hs),
        .bpu_to_ifu_hs_i  (bpu_hs),
        .bpu_to_ifu_i     (bpu_pred),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .deq_valid_o      (deq_valid),
        .deq_ready_i      (deq_ready),
        .deq_entry_o      (deq_entry),
        .deq_ftq_idx_o    (deq_idx),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    assign bpu_hs = '{valid: 1'b1, ready: bpu_rdy};

    // BPU stand-in: sequential fetch, or slot 2 taken to B+0x100 when the PC is B.
    always_comb begin
        bpu_pred     = '0;
        bpu_pred.npc = ifu_pc.pc + 32'h10;
        if (take_en && ifu_pc.pc == B) begin
            bpu_pred.pred_slot_valid  = 1'b1;
            bpu_pred.pred_slot_idx    = 2'd2;
            bpu_pred.pred_slot_target = B + 32'h100;
            bpu_pred.npc              = B + 32'h100;
        end
    end

    typedef struct {
        logic        rdy, dr, rd, take;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic        e_sv;
        logic [1:0]  e_si;
        logic [31:0] e_tgt, e_npc;
        int          e_cnt, e_head;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rdy, input logic dr, input logic rd, input logic [31:0] rpc);
        bpu_rdy   = rdy;
        deq_ready = dr;
        redir     = rd;
        redir_pc  = rpc;
        #1;
    endtask

    task automatic add(input logic rdy, dr, rd, take, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_pc, input logic e_dv,
                       input logic [31:0] e_dpc, input logic e_sv, input logic [1:0] e_si,
                       input logic [31:0] e_tgt, e_npc, input int e_cnt, e_head);
        vec_t v;
        v = '{rdy, dr, rd, take, rpc, e_req, e_pc, e_dv, e_dpc, e_sv, e_si, e_tgt, e_npc, e_cnt, e_head};
        vecs.push_back(v);
    endtask

    initial begin
        // rdy dr rd take rpc | req pc dv dpc sv si tgt npc cnt head
        add(1,1,0,0, 0,       1, B,        0, 0,        0,0, 0,        0,        0, 0);
        add(1,1,0,0, 0,       1, B+'h10,   1, B,        0,0, 0,        B+'h10,   1, 0);
        add(1,1,0,0, 0,       1, B+'h20,   1, B+'h10,   0,0, 0,        B+'h20,   1, 1);
        add(1,1,0,0, 0,       1, B+'h30,   1, B+'h20,   0,0, 0,        B+'h30,   1, 2);
        add(0,1,0,0, 0,       1, B+'h40,   1, B+'h30,   0,0, 0,        B+'h40,   1, 3);
        add(0,1,0,0, 0,       1, B+'h40,   0, 0,        0,0, 0,        0,        0, 4);
        add(1,1,1,0, B,       0, B+'h40,   0, 0,        0,0, 0,        0,        0, 4);
        add(1,0,0,1, 0,       1, B,        0, 0,        0,0, 0,        0,        0, 0);
        add(0,1,0,1, 0,       1, B+'h100,  1, B,        1,2, B+'h100,  B+'h100,  1, 0);
        add(0,0,0,0, 0,       1, B+'h100,  0, 0,        0,0, 0,        0,        0, 1);

        // Reset state while rst is held.
        drive(0, 0, 0, 0);
        tick(); tick();
        chk("rst_req_valid", 64'(req_hs.valid), 64'(0));
        chk("rst_deq_valid", 64'(deq_valid), 64'(0));
        chk("rst_pc", 64'(ifu_pc.pc), 64'(B));
        chk("rst_count", 64'(count), 64'(0));
        rst = 1'b0;
        tick();

        // Table: sequential fetch, drain, redirect, taken prediction.
        foreach (vecs[i]) begin
            take_en = vecs[i].take;
            drive(vecs[i].rdy, vecs[i].dr, vecs[i].rd, vecs[i].rpc);
            chk($sformatf("v%0d_req", i), 64'(req_hs.valid), 64'(vecs[i].e_req));
            chk($sformatf("v%0d_pc", i), 64'(ifu_pc.pc), 64'(vecs[i].e_pc));
            chk($sformatf("v%0d_dv", i), 64'(deq_valid), 64'(vecs[i].e_dv));
            chk($sformatf("v%0d_cnt", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_head", i), 64'(deq_idx), 64'(vecs[i].e_head));
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d_dpc", i), 64'(deq_entry.pc), 64'(vecs[i].e_dpc));
                chk($sformatf("v%0d_sv", i), 64'(deq_entry.pred_slot_valid), 64'(vecs[i].e_sv));
                chk($sformatf("v%0d_si", i), 64'(deq_entry.pred_slot_idx), 64'(vecs[i].e_si));
                chk($sformatf("v%0d_tgt", i), 64'(deq_entry.pred_slot_target), 64'(vecs[i].e_tgt));
                chk($sformatf("v%0d_npc", i), 64'(deq_entry.npc), 64'(vecs[i].e_npc));
            end
            tick();
        end
        take_en = 1'b0;

        // Fill with dequeue stalled: count saturates at DEPTH and the PC freezes.
        for (int i = 0; i < 12; i++) begin
            int n;
            n = (i < 8) ? i : 8;
            drive(1, 0, 0, 0);
            chk($sformatf("fill%0d_cnt", i), 64'(count), 64'(n));
            chk($sformatf("fill%0d_req", i), 64'(req_hs.valid), 64'(i < 8));
            chk($sformatf("fill%0d_pc", i), 64'(ifu_pc.pc), 64'(B + 32'h100 + 32'(16 * n)));
            tick();
        end
        drive(1, 1, 0, 0);
        chk("full_deq_dv", 64'(deq_valid), 64'(1));
        chk("full_deq_req", 64'(req_hs.valid), 64'(0));
        chk("full_deq_pc", 64'(deq_entry.pc), 64'(B + 32'h100));
        chk("full_deq_head", 64'(deq_idx), 64'(1));
        tick();
        drive(1, 0, 0, 0);
        chk("after_pop_cnt", 64'(count), 64'(7));
        chk("after_pop_req", 64'(req_hs.valid), 64'(1));
        chk("after_pop_pc", 64'(ifu_pc.pc), 64'(B + 32'h180));
        tick();
        drive(0, 0, 0, 0);
        chk("refill_cnt", 64'(count), 64'(8));
        chk("refill_pc", 64'(ifu_pc.pc), 64'(B + 32'h190));

        // Drain three entries to reach count 5, then redirect.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            chk($sformatf("drain%0d_pc", i), 64'(deq_entry.pc), 64'(B + 32'h110 + 32'(16 * i)));
            tick();
        end
        drive(1, 1, 1, B + 32'h400);
        chk("pre_redir_cnt", 64'(count), 64'(5));
        chk("pre_redir_req", 64'(req_hs.valid), 64'(0));
        tick();
        drive(1, 1, 0, 0);
        chk("redir_cnt", 64'(count), 64'(0));
        chk("redir_dv", 64'(deq_valid), 64'(0));
        chk("redir_req", 64'(req_hs.valid), 64'(1));
        chk("redir_pc", 64'(ifu_pc.pc), 64'(B + 32'h400));
        chk("redir_head", 64'(deq_idx), 64'(0));
        tick();
        drive(0, 0, 0, 0);
        chk("post_redir_dv", 64'(deq_valid), 64'(1));
        chk("post_redir_dpc", 64'(deq_entry.pc), 64'(B + 32'h400));
        chk("post_redir_cnt", 64'(count), 64'(1));

        // Back-to-back redirects: last one wins, queue stays empty.
        drive(1, 1, 1, B + 32'h500);
        tick();
        drive(1, 1, 1, B + 32'h600);
        chk("b2b_cnt", 64'(count), 64'(0));
        chk("b2b_pc1", 64'(ifu_pc.pc), 64'(B + 32'h500));
        tick();
        drive(1, 1, 0, 0);
        chk("b2b_pc2", 64'(ifu_pc.pc), 64'(B + 32'h600));
        chk("b2b_dv", 64'(deq_valid), 64'(0));
        chk("b2b_req", 64'(req_hs.valid), 64'(1));

        // Wrap: 20 enqueue/dequeue pairs, head index cycles 0..7.
        for (int k = 0; k <= 20; k++) begin
            drive(1, 1, 0, 0);
            chk($sformatf("wrap%0d_pc", k), 64'(ifu_pc.pc), 64'(B + 32'h600 + 32'(16 * k)));
            if (k > 0) begin
                chk($sformatf("wrap%0d_dv", k), 64'(deq_valid), 64'(1));
                chk($sformatf("wrap%0d_dpc", k), 64'(deq_entry.pc), 64'(B + 32'h600 + 32'(16 * (k - 1))));
                chk($sformatf("wrap%0d_idx", k), 64'(deq_idx), 64'((k - 1) % 8));
                chk($sformatf("wrap%0d_cnt", k), 64'(count), 64'(1));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
